// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: funct3 codes, FSM states
// and the access-size decoder.
package dmem_pkg;

   localparam logic [2:0] F3_BYTE = 3'b000;
   localparam logic [2:0] F3_HALF = 3'b001;
   localparam logic [2:0] F3_WORD = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   // Returns the byte count of an access, or 0 for an illegal funct3.
   function automatic logic [2:0] access_size(input logic [2:0] funct3);
      logic [2:0] size;
      case (funct3)
         F3_BYTE: size = 3'd1;
         F3_HALF: size = 3'd2;
         F3_WORD: size = 3'd4;
         default: size = 3'd0;
      endcase
      return size;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
// master: requesters plus memory; slave: the arbiter itself.
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 32
) ();

   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [1:0]          req_write;
   logic [5:0]          req_funct3;
   logic [2*ADDR_W-1:0] req_addr;
   logic [63:0]         req_wdata;
   logic [1:0]          resp_valid;
   logic [31:0]         resp_rdata;
   logic                resp_err;
   logic                mem_read;
   logic                mem_write;
   logic [2:0]          mem_funct3;
   logic [ADDR_W-1:0]   mem_addr;
   logic [31:0]         mem_wdata;
   logic [31:0]         mem_rdata;

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_read, mem_write, mem_funct3, mem_addr, mem_wdata
   );

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_read, mem_write, mem_funct3, mem_addr, mem_wdata
   );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module rr_arbiter2 (
   input  logic [1:0] i_req,
   input  logic       i_last_grant,
   output logic [1:0] o_gnt
);

   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = i_last_grant ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU
// (requester 0) and the debug/loader port (requester 1).
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned MEM_BYTES   = 1024,
   parameter bit          ALIGN_CHECK = 1'b1,
   parameter int unsigned ADDR_W      = 32
) (
   input logic           clock,
   input logic           reset,
   dmem_arbiter_if.slave bus
);

   state_e            r_state;
   logic              r_last_grant;
   logic              r_gnt_idx;
   logic              r_write;
   logic              r_err;
   logic [2:0]        r_funct3;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rdata;
   logic [1:0]        r_resp_valid;

   logic [1:0]        w_req;
   logic [1:0]        w_gnt;
   logic              w_gnt_idx;
   logic              w_write;
   logic [2:0]        w_funct3;
   logic [ADDR_W-1:0] w_addr;
   logic [31:0]       w_wdata;
   logic [2:0]        w_size;
   logic [ADDR_W:0]   w_end;
   logic              w_misalign;
   logic              w_err;

   // Requests are only visible to the arbiter in IDLE and out of reset.
   assign w_req = (r_state == ST_IDLE && !reset) ? bus.req_valid : 2'b00;

   rr_arbiter2 u_rr_arbiter2 (
      .i_req        (w_req),
      .i_last_grant (r_last_grant),
      .o_gnt        (w_gnt)
   );

   assign bus.req_ready = w_gnt;
   assign w_gnt_idx     = w_gnt[1];
   assign w_write       = w_gnt_idx ? bus.req_write[1] : bus.req_write[0];
   assign w_funct3      = w_gnt_idx ? bus.req_funct3[5:3] : bus.req_funct3[2:0];
   assign w_addr        = w_gnt_idx ? bus.req_addr[2*ADDR_W-1:ADDR_W]
                                    : bus.req_addr[ADDR_W-1:0];
   assign w_wdata       = w_gnt_idx ? bus.req_wdata[63:32] : bus.req_wdata[31:0];

   // End address is one bit wider than the address so a wrapping sum still fails.
   assign w_size     = access_size(w_funct3);
   assign w_end      = {1'b0, w_addr} + (ADDR_W+1)'(w_size);
   assign w_misalign = ALIGN_CHECK && ((w_size == 3'd2 && w_addr[0]) ||
                                       (w_size == 3'd4 && w_addr[1:0] != 2'b00));
   assign w_err      = (w_size == 3'd0) || (w_end > (ADDR_W+1)'(MEM_BYTES)) || w_misalign;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
         r_gnt_idx    <= 1'b0;
         r_write      <= 1'b0;
         r_err        <= 1'b0;
         r_funct3     <= 3'b000;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rdata      <= '0;
         r_resp_valid <= 2'b00;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_resp_valid <= 2'b00;
               if (w_gnt != 2'b00) begin
                  r_gnt_idx    <= w_gnt_idx;
                  r_last_grant <= w_gnt_idx;
                  r_write      <= w_write;
                  r_funct3     <= w_funct3;
                  r_addr       <= w_addr;
                  r_wdata      <= w_wdata;
                  r_err        <= w_err;
                  r_rdata      <= '0;
                  if (w_err) begin
                     r_state      <= ST_RESP;
                     r_resp_valid <= w_gnt;
                  end else begin
                     r_state <= ST_ACCESS;
                  end
               end
            end
            ST_ACCESS: begin
               r_rdata      <= r_write ? 32'd0 : bus.mem_rdata;
               r_resp_valid <= r_gnt_idx ? 2'b10 : 2'b01;
               r_state      <= ST_RESP;
            end
            ST_RESP: begin
               r_resp_valid <= 2'b00;
               r_state      <= ST_IDLE;
            end
            default: begin
               r_resp_valid <= 2'b00;
               r_state      <= ST_IDLE;
            end
         endcase
      end
   end

   // Strobes are gated by reset so a reset during ACCESS cancels the store.
   assign bus.mem_read   = (r_state == ST_ACCESS) && !r_write && !reset;
   assign bus.mem_write  = (r_state == ST_ACCESS) && r_write && !reset;
   assign bus.mem_funct3 = r_funct3;
   assign bus.mem_addr   = r_addr;
   assign bus.mem_wdata  = r_wdata;

   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_rdata = r_rdata;
   assign bus.resp_err   = r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory, request-level reference model,
// directed scenarios followed by randomized single-requester traffic.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   localparam int MEMB = 1024;

   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   logic [7:0] mem     [0:MEMB-1];
   logic [7:0] ref_mem [0:MEMB-1];
   logic [1:0] pend = 2'b00;

   always #5 clock = ~clock;

   dmem_arbiter_if #(.ADDR_W(32)) bus ();

   dmem_arbiter #(
      .MEM_BYTES   (1024),
      .ALIGN_CHECK (1'b1),
      .ADDR_W      (32)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   function automatic int sz_of(input logic [2:0] f3);
      case (f3)
         3'b000:  return 1;
         3'b001:  return 2;
         3'b010:  return 4;
         default: return 0;
      endcase
   endfunction

   always @(posedge clock) cyc <= cyc + 1;

   // Memory: combinational zero-extended read, store commits on the rising edge.
   always_comb begin
      bus.mem_rdata = '0;
      for (int i = 0; i < 4; i++) begin
         if (i < sz_of(bus.mem_funct3) && longint'(bus.mem_addr) + i < MEMB)
            bus.mem_rdata[8*i +: 8] = mem[bus.mem_addr + 32'(i)];
      end
   end

   always @(posedge clock) begin
      if (bus.mem_write) begin
         for (int i = 0; i < 4; i++) begin
            if (i < sz_of(bus.mem_funct3) && longint'(bus.mem_addr) + i < MEMB)
               mem[bus.mem_addr + 32'(i)] <= bus.mem_wdata[8*i +: 8];
         end
      end
   end

   // A requester must hold valid until it sees ready.
   always @(posedge clock) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset && pend[i] && !bus.req_valid[i]) begin
            errors++;
            $error("FAIL protocol: requester %0d dropped valid before ready", i);
         end
      end
      pend <= bus.req_valid & ~bus.req_ready;
   end

   function automatic bit ref_err(input logic [2:0] f3, input logic [31:0] a);
      int s;
      s = sz_of(f3);
      if (s == 0) return 1'b1;
      if (longint'(a) + s > MEMB) return 1'b1;
      if (s == 2 && a[0]) return 1'b1;
      if (s == 4 && a[1:0] != 2'b00) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < sz_of(f3); i++) v[8*i +: 8] = ref_mem[a + 32'(i)];
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int r, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
      bus.req_write[r]          = wr;
      bus.req_funct3[3*r +: 3]  = f3;
      bus.req_addr[32*r +: 32]  = a;
      bus.req_wdata[32*r +: 32] = wd;
      bus.req_valid[r]          = 1'b1;
   endtask

   // One transaction from requester r, checked end to end against the model.
   task automatic run_single(input int r, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd);
      bit          e;
      bit          got;
      int          acc;
      logic [31:0] exp_rd;
      e      = ref_err(f3, a);
      exp_rd = (e || wr) ? 32'd0 : ref_load(f3, a);
      got    = 1'b0;
      @(posedge clock); #1;
      set_req(r, wr, f3, a, wd);
      for (int n = 0; n < 20; n++) begin
         @(negedge clock);
         if (bus.req_ready[r]) begin
            got = 1'b1;
            break;
         end
      end
      check("accepted", 32'(got), 32'd1);
      check("ready_onehot", 32'(bus.req_ready), 32'd1 << r);
      acc = cyc;
      @(posedge clock); #1;
      bus.req_valid[r] = 1'b0;
      if (!e) begin
         @(negedge clock);
         check("acc_mem_write", 32'(bus.mem_write), 32'(wr));
         check("acc_mem_read", 32'(bus.mem_read), 32'(!wr));
         check("acc_mem_addr", bus.mem_addr, a);
         if (wr) check("acc_mem_wdata", bus.mem_wdata, wd);
      end
      @(negedge clock);
      check("resp_valid", 32'(bus.resp_valid), 32'd1 << r);
      check("resp_latency", 32'(cyc - acc), e ? 32'd1 : 32'd2);
      check("resp_err", 32'(bus.resp_err), 32'(e));
      check("resp_rdata", bus.resp_rdata, exp_rd);
      if (e) check("err_no_strobe", 32'({bus.mem_read, bus.mem_write}), 32'd0);
      @(negedge clock);
      check("resp_pulse", 32'(bus.resp_valid), 32'd0);
      if (wr && !e)
         for (int i = 0; i < sz_of(f3); i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
   endtask

   initial begin
      int          cnt;
      int          g;
      int          exp_g;
      int          r;
      bit          wr;
      int          pick;
      int          mode;
      logic [2:0]  f3;
      logic [31:0] a;

      for (int i = 0; i < MEMB; i++) begin
         mem[i]     <= 8'h00;
         ref_mem[i] = 8'h00;
      end
      reset          = 1'b1;
      bus.req_valid  = 2'b00;
      bus.req_write  = 2'b00;
      bus.req_funct3 = '0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;

      // Reset state, with both requesters already asserting LB requests.
      repeat (2) @(posedge clock);
      #1;
      set_req(0, 1'b0, F3_BYTE, 32'd5, 32'd0);
      set_req(1, 1'b0, F3_BYTE, 32'd6, 32'd0);
      @(negedge clock);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_resp_err", 32'(bus.resp_err), 32'd0);
      check("rst_resp_rdata", bus.resp_rdata, 32'd0);
      check("rst_strobes", 32'({bus.mem_read, bus.mem_write}), 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Tie: grants alternate starting with requester 0.
      cnt   = 0;
      exp_g = 0;
      for (int n = 0; n < 80 && cnt < 9; n++) begin
         @(negedge clock);
         if (bus.req_ready != 2'b00) begin
            g = bus.req_ready[1] ? 1 : 0;
            check("tie_grant", 32'(bus.req_ready), 32'd1 << exp_g);
            exp_g = 1 - exp_g;
            cnt++;
            @(posedge clock); #1;
            if (cnt >= 8) bus.req_valid[g] = 1'b0;
         end
      end
      check("tie_grant_count", 32'(cnt), 32'd9);
      bus.req_valid = 2'b00;
      repeat (4) @(posedge clock);

      run_single(0, 1'b1, F3_WORD, 32'h10, 32'hDEADBEEF);
      run_single(1, 1'b0, F3_WORD, 32'h10, 32'd0);
      check("sw_lw_data", ref_load(F3_WORD, 32'h10), 32'hDEADBEEF);

      run_single(0, 1'b1, F3_WORD, 32'h20, 32'hA5A5A5A5);
      run_single(0, 1'b1, F3_HALF, 32'h21, 32'h00001234);
      run_single(1, 1'b0, F3_WORD, 32'h20, 32'd0);

      run_single(0, 1'b0, F3_WORD, 32'd1022, 32'd0);
      run_single(0, 1'b0, F3_WORD, 32'd1020, 32'd0);
      run_single(1, 1'b0, F3_WORD, 32'hFFFFFFFE, 32'd0);
      run_single(1, 1'b0, 3'b011, 32'h10, 32'd0);

      // Reset during ACCESS suppresses the store and its response.
      run_single(0, 1'b1, F3_WORD, 32'h40, 32'hCAFEF00D);
      @(posedge clock); #1;
      set_req(0, 1'b1, F3_WORD, 32'h40, 32'h12345678);
      @(negedge clock);
      check("rmid_accept", 32'(bus.req_ready), 32'd1);
      @(posedge clock); #1;
      bus.req_valid = 2'b00;
      reset         = 1'b1;
      @(negedge clock);
      check("rmid_no_write", 32'(bus.mem_write), 32'd0);
      check("rmid_no_read", 32'(bus.mem_read), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clock);
         check("rmid_no_resp", 32'(bus.resp_valid), 32'd0);
      end
      run_single(1, 1'b0, F3_WORD, 32'h40, 32'd0);

      for (int t = 0; t < 40; t++) begin
         r    = int'($urandom_range(0, 1));
         wr   = 1'($urandom_range(0, 1));
         pick = int'($urandom_range(0, 9));
         f3   = (pick == 9) ? 3'($urandom_range(3, 7)) : 3'(pick % 3);
         mode = int'($urandom_range(0, 7));
         if (mode == 0) a = $urandom;
         else if (mode == 1) a = 32'(MEMB) - 32'($urandom_range(0, 4));
         else a = 32'($urandom_range(0, MEMB - 1));
         if (mode > 2 && sz_of(f3) > 1) a = a & ~32'(sz_of(f3) - 1);
         run_single(r, wr, f3, a, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port byte-addressed data memory between two requesters.
- Requester 0 is the CPU load/store stage; requester 1 is the debug/loader port.
- Performs round-robin arbitration, validates each request (funct3, bounds, alignment), drives the memory strobes for exactly one cycle, and returns a registered response.
- Sits between the requesters and the data memory; the memory itself is unchanged.

Parameters:
- MEM_BYTES, 1024: memory size in bytes; used for the bounds check.
- ALIGN_CHECK, 1: 1 flags misaligned LH/SH (addr[0]≠0) and LW/SW (addr[1:0]≠0) as errors; 0 disables the check.
- ADDR_W, 32: address width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  2  bit i: requester i has a request.
- req_ready  output  2  bit i: request i accepted this cycle (one-hot or zero).
- req_write  input  2  bit i: 1=store, 0=load.
- req_funct3  input  6  [3i+2:3i]: 000 byte, 001 half, 010 word.
- req_addr  input  2*ADDR_W  [ADDR_W*i+:ADDR_W]: byte address.
- req_wdata  input  64  [32i+:32]: store data.
- resp_valid  output  2  bit i: response for requester i (one-cycle pulse).
- resp_rdata  output  32  load data; shared; valid with resp_valid.
- resp_err  output  1  request rejected; valid with resp_valid.
- mem_read  output  1  to memory MemRead.
- mem_write  output  1  to memory MemWrite.
- mem_funct3  output  3  to memory funct3.
- mem_addr  output  32  to memory address.
- mem_wdata  output  32  to memory write_data.
- mem_rdata  input  32  from memory read_data (combinational).

Behaviour:
- FSM states:
  - IDLE: if any req_valid is set, grant one requester: assert req_ready[g] combinationally this cycle, latch write/funct3/addr/wdata/g and the error flag, then go to ACCESS (or RESP if the error flag is set). Otherwise stay in IDLE.
  - ACCESS: drive mem_* from the latched request. mem_read=~write, mem_write=write, for exactly this one cycle; the store commits at this cycle's rising edge. For loads, register mem_rdata into resp_rdata at that edge. Go to RESP.
  - RESP: resp_valid[g]=1 for one cycle with resp_rdata/resp_err held. Go to IDLE.
- Latency: accept at cycle N, memory access at N+1, response at N+2. Throughput is one access per 3 cycles; req_ready is low outside IDLE.
- Arbitration:
  - Only one valid request: grant it.
  - Both valid: grant the requester not granted last; the last_grant register updates on each grant.
  - A request is held by its requester (valid and fields stable) until req_ready.
- Error flag is set if any of the following hold:
  - funct3 is not in {000,001,010};
  - addr + size > MEM_BYTES, with size 1/2/4 and the sum computed in ADDR_W+1 bits so wrap-around cannot pass;
  - ALIGN_CHECK=1 and the access is misaligned.
- On error:
  - ACCESS is skipped and no mem strobe is asserted.
  - resp_err=1 and resp_rdata=0.
  - Errors are reported for loads and stores alike.
- Loads return memory data as-is (zero-extended by the memory); resp_rdata=0 for stores.
- Idle bus values:
  - mem_read and mem_write are 0 outside ACCESS.
  - mem_addr, mem_wdata and mem_funct3 hold the last latched values.
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins the first tie), resp_valid=0, resp_err=0, resp_rdata=0.
  - Latched request registers are 0.
  - req_ready=0 while reset is high.
- Reset mid-operation:
  - mem_write and mem_read are gated with ~reset combinationally, so reset asserted during ACCESS suppresses the store.
  - No response is emitted for the aborted request.
- A requester deasserting valid before ready is a protocol violation; no recovery is required, and the bench asserts it never occurs.

Decomposition:
- Shared package dmem_pkg:
  - funct3 constants F3_BYTE=3'b000, F3_HALF=3'b001, F3_WORD=3'b010;
  - state encodings ST_IDLE, ST_ACCESS, ST_RESP;
  - function access_size(funct3) returning 1/2/4, or 0 for illegal.
- One natural sub-module: rr_arbiter2, a combinational grant from req_valid[1:0] and last_grant, producing a one-hot grant.
- The error check stays inline.

Test Plan:
- Single SW from r0: addr=0x10, wdata=0xDEADBEEF, then LW from r1 at 0x10 → r1 resp_rdata=0xDEADBEEF, resp_err=0; accept-to-response is 2 cycles each.
- Both valid from reset, each repeating LB requests → grants alternate r0,r1,r0,r1; no requester is starved over 8 grants.
- SH addr=0x21 with ALIGN_CHECK=1 → resp_err=1; mem_write never asserted; the bytes at 0x20–0x23 are unchanged on readback.
- LW addr=1022 (MEM_BYTES=1024) → resp_err=1. LW addr=1020 → resp_err=0. LW addr=0xFFFFFFFE → resp_err=1 (no wrap).
- funct3=3'b011 from r1 → resp_err=1, resp_rdata=0, no mem strobes.
- SW 0x12345678 to 0x40, then reset asserted in its ACCESS cycle → mem_write stays 0, no resp_valid, and a later LW of 0x40 returns the prior value.
